nibble_serial_adder_ctrl: RTL and testbench
===========================================

NIBBLE_SERIAL_ADDER_CTRL -- requirements
Module: nibble_serial_adder_ctrl

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 2..8.
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: start  input  1  request to begin one addition; sampled on clk.
REQ-005 Port: A  input  W  operand A; captured when start is accepted.
REQ-006 Port: B  input  W  operand B; captured when start is accepted.
REQ-007 Port: Cin  input  1  carry-in; captured when start is accepted.
REQ-008 Port: busy  output  1  high while an addition is in progress (states RUN and DONE).
REQ-009 Port: done  output  1  one-cycle completion pulse.
REQ-010 Port: sum  output  W  registered result.
REQ-011 Port: Cout  output  1  registered final carry-out.

Function
REQ-012 The block SHALL use exactly one 4-bit adder slice (A4, B4, carry-in -> sum4, carry-out), time-shared across nibbles, LSB nibble first.
REQ-013 The block SHALL implement FSM states IDLE, RUN and DONE, with an internal nibble index in 0..NIBBLES-1 and a 1-bit carry register.
REQ-014 IDLE: start=1 at an edge SHALL capture A, B and Cin, clear the index to 0, and move to RUN; start=0 SHALL stay in IDLE.
REQ-015 RUN: each edge SHALL add nibble[index] of A and B plus the carry register, store the 4-bit result into nibble[index] of an internal shadow register, load the carry register with the slice carry-out, and increment the index.
REQ-016 RUN with index=NIBBLES-1: the edge SHALL copy the shadow register to sum and the final carry to Cout, and move to DONE.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-018 Latency: start accepted at edge 0 -> sum/Cout valid and done=1 after edge NIBBLES; the next start is accepted no earlier than edge NIBBLES+2.
REQ-019 start in RUN or DONE SHALL be ignored, with no queuing; operand changes after capture SHALL have no effect.
REQ-020 sum and Cout SHALL update only at completion (REQ-016) and SHALL hold their value until the next completion.
REQ-021 Arithmetic SHALL be modulo 2^W on sum, with Cout = bit W of A+B+Cin; wrap-around (e.g. all-ones + 1) SHALL produce sum=0 and Cout=1.
REQ-022 done SHALL never be high in IDLE or RUN; busy SHALL be 0 in IDLE.

Reset
REQ-023 rst=1 SHALL immediately force: state=IDLE, index=0, carry register=0, shadow register=0, sum=0, Cout=0, busy=0, done=0.
REQ-024 rst asserted mid-operation SHALL abort the addition with no done pulse; the first start after rst deasserts SHALL behave as from power-up.

Configuration
REQ-025 Macro ADDER_SUB_EN, defined: adds port "sub  input  1", captured together with the operands; sub=1 computes A - B as A + ~B with carry-in forced to 1 (Cin ignored), and Cout=1 means no borrow; sub=0 behaves as an add.
REQ-026 Macro ADDER_SUB_EN, undefined: port sub is absent and the block is add-only, exactly per REQ-012..REQ-022.

Verification (NIBBLES=4)
REQ-027 A=0x0000, B=0x0001, Cin=0, start pulse -> done exactly 4 cycles after the start edge, sum=0x0001, Cout=0.
REQ-028 A=0x1234, B=0x5678, Cin=0 -> sum=0x68AC, Cout=0; busy high for 5 cycles.
REQ-029 A=0xFFFF, B=0x0001, Cin=1 -> sum=0x0001, Cout=1 (carry ripples through all nibbles).
REQ-030 Start 0x1111+0x2222, then start=1 with 0xFFFF+0xFFFF during RUN -> one done only, sum=0x3333; the second request is dropped.
REQ-031 rst pulse during the 2nd RUN cycle -> all outputs 0 immediately, no done; a new start of 0x000F+0x0001 -> sum=0x0010, Cout=0.
REQ-032 ADDER_SUB_EN defined, sub=1, A=0x0005, B=0x0007 -> sum=0xFFFE, Cout=0; A=0x0007, B=0x0005 -> sum=0x0002, Cout=1.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder: one 4-bit slice reused LSB-first over NIBBLES nibbles.
// Optional subtract mode is enabled by defining ADDER_SUB_EN.
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] A,
    input  logic [4*NIBBLES-1:0] B,
    input  logic                 Cin,
`ifdef ADDER_SUB_EN
    input  logic                 sub,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 Cout
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [W-1:0]    shadow, shadow_nx;
    logic [W-1:0]    a_r, b_r;
    logic [IW+1:0]   off;
    logic [3:0]      a4, b4;
    logic [4:0]      slice;
    logic            last;
    logic [W-1:0]    b_cap;
    logic            c_cap;

    assign off   = {idx, 2'b00};
    assign a4    = a_r[off +: 4];
    assign b4    = b_r[off +: 4];
    assign slice = {1'b0, a4} + {1'b0, b4} + {4'b0000, carry};
    assign last  = (idx == IW'(NIBBLES - 1));

`ifdef ADDER_SUB_EN
    assign b_cap = sub ? ~B : B;
    assign c_cap = sub ? 1'b1 : Cin;
`else
    assign b_cap = B;
    assign c_cap = Cin;
`endif

    // Shadow with the current nibble's slice result merged in
    always_comb begin
        shadow_nx = shadow;
        shadow_nx[off +: 4] = slice[3:0];
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic and status outputs
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (start) state_nx = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, per-nibble accumulation and result commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            carry  <= 1'b0;
            shadow <= '0;
            a_r    <= '0;
            b_r    <= '0;
            sum    <= '0;
            Cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_r   <= A;
                    b_r   <= b_cap;
                    carry <= c_cap;
                    idx   <= '0;
                end
                RUN: begin
                    shadow <= shadow_nx;
                    carry  <= slice[4];
                    if (last) begin
                        idx  <= '0;
                        sum  <= shadow_nx;
                        Cout <= slice[4];
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for nibble_serial_adder_ctrl (NIBBLES=4).
// Define ADDER_SUB_EN to also exercise subtract mode.
module tb_nibble_serial_adder_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done, cout;
    logic [W-1:0] sum;
`ifdef ADDER_SUB_EN
    logic         sub;
`endif

    int n_chk = 0;
    int n_pass = 0;
    int done_cnt = 0;
    logic [W:0] sb[$];

    nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a),
        .B     (b),
        .Cin   (cin),
`ifdef ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .Cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    // Compare committed results against the scoreboard on every done pulse
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            chk("done_busy", 32'(busy), 32'd1);
            if (sb.size() == 0) begin
                chk("spurious_done", 32'(done), 32'd0);
            end else begin
                logic [W:0] e;
                e = sb.pop_front();
                chk("sum", 32'(sum), 32'(e[W-1:0]));
                chk("cout", 32'(cout), 32'(e[W]));
            end
        end
    end

    // One operation; spam keeps start high with junk operands during RUN
    task automatic op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                      input logic ci, input logic si, input logic spam);
        int lat;
        int bsy;
        logic [W:0] e;
        @(negedge clk);
        a = ai; b = bi; cin = ci; start = 1'b1;
`ifdef ADDER_SUB_EN
        sub = si;
        if (si) e = {1'b0, ai} + {1'b0, ~bi} + (W+1)'(1);
        else    e = {1'b0, ai} + {1'b0, bi} + (W+1)'(ci);
`else
        e = {1'b0, ai} + {1'b0, bi} + (W+1)'(ci);
        if (si) e = e;
`endif
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = spam;
        if (spam) begin a = '1; b = '1; cin = 1'b1; end
        lat = 0;
        bsy = busy ? 1 : 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (busy) bsy++;
            if (done) begin lat = i; break; end
        end
        start = 1'b0;
        chk("latency", 32'(lat), 32'(N));
        @(posedge clk);
        #1;
        chk("busy_cycles", 32'(bsy), 32'(N + 1));
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int dc;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef ADDER_SUB_EN
        sub = 1'b0;
`endif
        #1;
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        op(16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0);
        op(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0);
        op(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0);
        op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        op(16'h8421, 16'h7BDE, 1'b1, 1'b0, 1'b0);

        dc = done_cnt;
        op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
        chk("drop_one_done", 32'(done_cnt - dc), 32'd1);
        chk("drop_sum", 32'(sum), 32'h3333);

        for (int k = 0; k < 4; k++)
            op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b0);

        // Abort during the second RUN cycle
        dc = done_cnt;
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - dc), 32'd0);
        op(16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0);

`ifdef ADDER_SUB_EN
        op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
        op(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b0);
        op(16'h0007, 16'h0005, 1'b1, 1'b0, 1'b0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_left", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
